// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the multi-channel set/clear/trigger controller:
// Gray-coded channel states, request bundle and timer sizing.
package seq_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_LATCH = 2'b01;
    localparam logic [STATE_W-1:0] ST_PULSE = 2'b11;
    localparam logic [STATE_W-1:0] ST_HOLD  = 2'b10;

    typedef struct packed {
        logic set;
        logic clr;
        logic trig;
    } req_t;

    // Timer must hold PULSE_LEN-1; keep at least one bit so PULSE_LEN=1 still elaborates.
    function automatic int timer_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic logic only_set(input req_t r);
        return r.set & ~r.clr & ~r.trig;
    endfunction

    function automatic logic only_clr(input req_t r);
        return r.clr & ~r.set & ~r.trig;
    endfunction

    function automatic logic only_trig(input req_t r);
        return r.trig & ~r.set & ~r.clr;
    endfunction

endpackage

// File: rtl/seq_ctrl_chan.sv
// One controller channel: Moore FSM (IDLE/LATCH/PULSE/HOLD), pulse timer
// and a saturating count of IDLE->PULSE transitions.
module seq_chan
    import seq_ctrl_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             clr,
    input  logic             trig,
    input  logic             cnt_clr,
    output logic             f,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt
);

    localparam int TW = timer_w(PULSE_LEN);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(PULSE_LEN - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fire;
    req_t               req;

    assign req = '{set: set, clr: clr, trig: trig};

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (only_set(req)) begin
                    state_d = ST_LATCH;
                end else if (only_trig(req)) begin
                    state_d = ST_PULSE;
                    timer_d = TIMER_LOAD;
                    fire    = 1'b1;
                end
            end
            ST_LATCH: begin
                if (only_clr(req)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HOLD: begin
                // A trigger still held from the last pulse keeps the channel parked here.
                if (!only_trig(req)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (fire && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    assign f     = (state_q == ST_LATCH) || (state_q == ST_PULSE);
    assign state = state_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-channel set/clear/trigger controller: CH independent seq_chan
// instances with their outputs packed onto flat buses.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int CH        = 4,
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       set,
    input  logic [CH-1:0]       clr,
    input  logic [CH-1:0]       trig,
    input  logic                cnt_clr,
    output logic [CH-1:0]       f,
    output logic [2*CH-1:0]     state,
    output logic [CH*CNT_W-1:0] pulse_cnt
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        seq_chan #(
            .PULSE_LEN (PULSE_LEN),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .set     (set[i]),
            .clr     (clr[i]),
            .trig    (trig[i]),
            .cnt_clr (cnt_clr),
            .f       (f[i]),
            .state   (state[STATE_W*i +: STATE_W]),
            .cnt     (pulse_cnt[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: vector table on a PULSE_LEN=3/CNT_W=2 instance,
// plus hand sequences for saturation, async reset and held trigger (PULSE_LEN=2).
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  set, clr, trig;
    logic        cnt_clr;
    logic [3:0]  fa, fb;
    logic [7:0]  sa, sb;
    logic [7:0]  ca;
    logic [31:0] cb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_ctrl #(.CH(4), .PULSE_LEN(3), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .set(set), .clr(clr), .trig(trig),
        .cnt_clr(cnt_clr), .f(fa), .state(sa), .pulse_cnt(ca)
    );

    seq_ctrl #(.CH(4), .PULSE_LEN(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .set(set), .clr(clr), .trig(trig),
        .cnt_clr(cnt_clr), .f(fb), .state(sb), .pulse_cnt(cb)
    );

    typedef struct {
        logic [3:0] set;
        logic [3:0] clr;
        logic [3:0] trig;
        logic       cnt_clr;
        logic [3:0] f;
        logic [7:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_a, hi_b;

        //            set      clr      trig     cc    f        state   cnt
        tv[0]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 8'h01, 8'h00};
        tv[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 8'h01, 8'h00};
        tv[2]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, 8'h01, 8'h00};
        tv[3]  = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00};
        tv[4]  = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0000, 8'h00, 8'h00};
        tv[5]  = '{4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b0100, 8'h30, 8'h10};
        tv[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 8'h30, 8'h10};
        tv[7]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 8'h30, 8'h10};
        tv[8]  = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000, 8'h20, 8'h10};
        tv[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 8'h10};
        tv[10] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 8'h40, 8'h10};
        tv[11] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 8'h40, 8'h10};
        tv[12] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b0000, 8'h00, 8'h10};

        rst = 1'b0; set = '0; clr = '0; trig = '0; cnt_clr = 1'b0;
        #1;
        chk("reset_f",     32'(fa), 32'h0);
        chk("reset_state", 32'(sa), 32'h0);
        chk("reset_cnt",   32'(ca), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            set = tv[i].set; clr = tv[i].clr; trig = tv[i].trig; cnt_clr = tv[i].cnt_clr;
            tick();
            chk($sformatf("v%0d_f", i),     32'(fa), 32'(tv[i].f));
            chk($sformatf("v%0d_state", i), 32'(sa), 32'(tv[i].st));
            chk($sformatf("v%0d_cnt", i),   32'(ca), 32'(tv[i].cnt));
        end
        set = '0; clr = '0; trig = '0; cnt_clr = 1'b0;

        // Saturation of ch1 counter (CNT_W=2): 5 pulses -> 3
        for (int n = 1; n <= 5; n++) begin
            trig = 4'b0010;
            tick();
            trig = '0;
            repeat (4) tick();
            chk($sformatf("sat_p%0d", n), 32'(ca[3:2]), (n > 3) ? 32'd3 : 32'(n));
        end
        trig = 4'b0010; cnt_clr = 1'b1;
        tick();
        trig = '0; cnt_clr = 1'b0;
        chk("sat_clr_cnt",   32'(ca), 32'h0);
        chk("sat_clr_state", 32'(sa), 32'h0C);
        repeat (4) tick();
        chk("sat_idle", 32'(sa), 32'h0);

        // Asynchronous reset with ch0 in LATCH and ch1 in PULSE
        set = 4'b0001;
        tick();
        set = '0; trig = 4'b0010;
        tick();
        trig = '0;
        chk("pre_rst_f",     32'(fa), 32'h3);
        chk("pre_rst_state", 32'(sa), 32'h0D);
        chk("pre_rst_cnt",   32'(ca[3:2]), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_f",     32'(fa), 32'h0);
        chk("mid_rst_state", 32'(sa), 32'h0);
        chk("mid_rst_cnt",   32'(ca), 32'h0);
        chk("mid_rst_cnt_b", cb, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Held trigger on ch0: one pulse per assertion
        trig = 4'b0001;
        hi_a = 0; hi_b = 0;
        repeat (20) begin
            tick();
            if (fb[0]) hi_b++;
            if (fa[0]) hi_a++;
        end
        chk("held_width_b", 32'(hi_b), 32'd2);
        chk("held_width_a", 32'(hi_a), 32'd3);
        chk("held_hold_b",  32'(sb[1:0]), 32'h2);
        trig = '0;
        tick();
        chk("held_rel_b", 32'(sb[1:0]), 32'h0);
        trig = 4'b0001;
        hi_b = 0;
        repeat (6) begin
            tick();
            if (fb[0]) hi_b++;
        end
        trig = '0;
        chk("rearm_width_b", 32'(hi_b), 32'd2);
        chk("rearm_cnt_b",   32'(cb[7:0]), 32'd2);
        chk("rearm_cnt_a",   32'(ca[1:0]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
